// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller driving a single 1-bit adder cell LSB first
// Optional feature macro: SERIAL_ADD_CTRL_SUB_EN (enables OP=1 subtraction; otherwise OP is ignored)
// Ports:
//   CLK    - sole clock, rising edge
//   RST_N  - asynchronous active-low reset
//   START  - begin an operation (accepted only in IDLE)
//   OP     - 0 = A+B, 1 = A-B (only with SERIAL_ADD_CTRL_SUB_EN)
//   A, B   - operands, sampled when START is accepted
//   BUSY   - high in RUN and FIN
//   DONE   - one-cycle pulse in FIN marking a valid result
//   SUM    - result register, filled from the MSB end
//   COUT   - carry out of the MSB (for subtraction: 1 = no borrow)
//   OVF    - two's-complement signed overflow
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, arm_q, arm_d;
    logic             op_eff;
    logic [WIDTH-1:0] b_in;
    logic             h1_s, h1_c, h2_c, s, c;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    // A-B is A + ~B + 1: invert B at load and seed the carry with OP
    assign op_eff = OP;
    assign b_in   = OP ? ~B : B;
`else
    logic unused_op;
    assign unused_op = OP;
    assign op_eff    = 1'b0;
    assign b_in      = B;
`endif

    // full adder built from two half-adder stages plus OR for the carry
    assign h1_s = a_q[0] ^ b_q[0];
    assign h1_c = a_q[0] & b_q[0];
    assign s    = h1_s ^ carry_q;
    assign h2_c = h1_s & carry_q;
    assign c    = h1_c | h2_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        arm_d   = arm_q;
        case (state_q)
            IDLE: if (START) begin
                a_d     = A;
                b_d     = b_in;
                carry_d = op_eff;
                cnt_d   = '0;
                arm_d   = 1'b1;
                state_d = RUN;
            end
            RUN: if (arm_q) begin
                // first RUN cycle lets the loaded operands settle so DONE lands WIDTH+1 edges after acceptance
                arm_d = 1'b0;
            end else begin
                sum_d   = {s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c;
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = c;
                    ovf_d   = carry_q ^ c;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            arm_q   <= arm_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = (state_q == FIN);
    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench for serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        START = 1'b0;
    logic        OP = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE, COUT, OVF;
    logic [31:0] SUM;
    int          checks = 0;
    int          errors = 0;

    serial_add_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic op_in, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] es, output logic ec, output logic eo);
        logic [32:0] t;
        logic        op;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        op = op_in;
`else
        op = 1'b0 & op_in;
`endif
        if (op) begin
            es = a - b;
            ec = (a >= b);
            eo = (a[31] != b[31]) && (es[31] != a[31]);
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            es = t[31:0];
            ec = t[32];
            eo = (a[31] == b[31]) && (es[31] != a[31]);
        end
    endfunction

    task automatic run_exp(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] es, input logic ec, input logic eo, input string tag);
        int n;
        n = 0;
        while (BUSY && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        chk({tag, " idle"}, BUSY, 0);
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        do begin
            A = $urandom; B = $urandom; OP = 1'($urandom);
            START = 1'($urandom_range(0, 1));
            @(posedge CLK); #1; n++;
        end while (!DONE && n < 100);
        chk({tag, " latency"}, n, 33);
        chk({tag, " busy at done"}, BUSY, 1);
        chk({tag, " sum"}, SUM, es);
        chk({tag, " cout"}, COUT, ec);
        chk({tag, " ovf"}, OVF, eo);
        @(posedge CLK); #1;
        START = 1'b0;
        chk({tag, " done width"}, DONE, 0);
        chk({tag, " start in fin ignored"}, BUSY, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk({tag, " hold"}, {SUM, COUT, OVF}, {es, ec, eo});
    endtask

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] es;
        logic        ec, eo;
        model(op, a, b, es, ec, eo);
        run_exp(op, a, b, es, ec, eo, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] qs;
        logic        qc, qo, prev_done, first;
        int          low_run, ops, dones;
        #1 RST_N = 1'b0;
        #1;
        chk("reset outputs", {BUSY, DONE, SUM, COUT, OVF}, 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        run_exp(1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, "add5_3");
        run_exp(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "add_wrap");
        run_exp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "add_ovf");
`ifdef SERIAL_ADD_CTRL_SUB_EN
        run_exp(1'b1, 32'd10, 32'd3, 32'd7, 1'b1, 1'b0, "sub10_3");
        run_exp(1'b1, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 1'b0, "sub3_10");
        run_exp(1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
`else
        run_exp(1'b1, 32'd10, 32'd3, 32'd13, 1'b0, 1'b0, "op_ignored");
`endif
        for (int i = 0; i < 16; i++) run_op(1'($urandom), $urandom, $urandom, "rand");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "rand_edge");

        // START held high with operands changing every cycle
        START = 1'b1; low_run = 0; ops = 0; first = 1'b1; prev_done = 1'b0;
        qs = '0; qc = 1'b0; qo = 1'b0;
        for (int c = 0; c < 300 && ops < 3; c++) begin
            A = $urandom; B = $urandom; OP = 1'($urandom);
            if (!BUSY) begin
                model(OP, A, B, qs, qc, qo);
                low_run++;
            end else if (low_run != 0) begin
                if (!first) chk("b2b idle gap", low_run, 1);
                first = 1'b0;
                low_run = 0;
            end
            @(posedge CLK); #1;
            if (DONE) begin
                ops++;
                chk("b2b done single", prev_done, 0);
                chk("b2b result", {SUM, COUT, OVF}, {qs, qc, qo});
            end
            prev_done = DONE;
        end
        chk("b2b ops completed", ops, 3);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // reset mid-operation, after a result with nonzero SUM and OVF
        run_exp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, "pre_reset");
        START = 1'b1; OP = 1'b0; A = 32'h1234_5678; B = 32'h0F0F_0F0F;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("mid reset outputs", {BUSY, DONE, SUM, COUT, OVF}, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1;
            if (DONE) dones++;
        end
        chk("no done after abort", dones, 0);
        run_exp(1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
